// File: rtl/alu_control_mc.sv
// alu_control_mc: registered multi-cycle ALU control unit.
// It decodes the main-control alu_op class and the R-type funct field into an
// ALU op code, with one register stage. It also sequences the mult/div unit
// through a start pulse, a busy window and a done pulse.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   in_valid        alu_op/funct are valid this cycle
//   in_ready        block can accept an input (state is IDLE)
//   alu_op, funct   main-control ALU class and instruction funct field
//   op, op_valid    registered op code and its one-cycle valid pulse
//   illegal         one-cycle pulse for an unsupported funct
//   md_start        one-cycle start pulse to the mult/div unit
//   md_kind         00 mult, 01 multu, 10 div, 11 divu (held between ops)
//   md_done         one-cycle pulse when the mult/div result is ready
//
// Optional build macro ALU_CTRL_PERF_EN adds perf_stall_cnt, a saturating
// 16-bit count of cycles with in_valid=1 while in_ready=0.
//
// state | meaning
// IDLE  | ready; decodes and registers one input per cycle
// BUSY  | mult/div running; counter counts down to 0
// DONE  | md_done/op_valid pulse is visible; back to IDLE next

module alu_control_mc #(
    parameter int OP_W    = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [5:0]      funct,
    output logic [OP_W-1:0] op,
    output logic            op_valid,
    output logic            illegal,
    output logic            md_start,
    output logic [1:0]      md_kind,
    output logic            md_done
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]     perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CODE_MD = 4'b1000;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [OP_W-1:0]   op_d;
    logic [1:0]        md_kind_d;
    logic              op_valid_d, illegal_d, md_start_d, md_done_d;

    logic [3:0]        dec_code;
    logic              dec_legal;
    logic              dec_md;

    always_comb begin
        dec_code  = 4'b0000;
        dec_legal = 1'b1;
        dec_md    = 1'b0;
        case (alu_op)
            2'b00: dec_code = 4'b0010;
            2'b10: dec_code = 4'b0110;
            default: begin
                case (funct)
                    6'b100000: dec_code = 4'b0010;
                    6'b100010: dec_code = 4'b0110;
                    6'b100100: dec_code = 4'b0000;
                    6'b100101: dec_code = 4'b0001;
                    6'b100111: dec_code = 4'b1100;
                    6'b101010: dec_code = 4'b0111;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        dec_code = CODE_MD;
                        dec_md   = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
        endcase
    end

    assign in_ready = (state == IDLE);

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        op_d       = op;
        md_kind_d  = md_kind;
        op_valid_d = 1'b0;
        illegal_d  = 1'b0;
        md_start_d = 1'b0;
        md_done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (!dec_legal) begin
                        illegal_d = 1'b1;
                        op_d      = '0;
                    end else if (dec_md) begin
                        state_d    = BUSY;
                        md_start_d = 1'b1;
                        md_kind_d  = funct[1:0];
                        // funct[1] separates div/divu from mult/multu
                        cnt_d      = funct[1] ? DIV_CNT : MUL_CNT;
                    end else begin
                        op_d       = OP_W'(dec_code);
                        op_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_d    = DONE;
                    md_done_d  = 1'b1;
                    op_valid_d = 1'b1;
                    op_d       = OP_W'(CODE_MD);
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            md_kind  <= 2'b00;
            op_valid <= 1'b0;
            illegal  <= 1'b0;
            md_start <= 1'b0;
            md_done  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            op       <= op_d;
            md_kind  <= md_kind_d;
            op_valid <= op_valid_d;
            illegal  <= illegal_d;
            md_start <= md_start_d;
            md_done  <= md_done_d;
        end
    end

`ifdef ALU_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cnt <= 16'h0000;
        end else if (in_valid && !in_ready && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
